// File: rtl/seq_squarer_pkg.sv
// Shared types and a reference square function for the sequential squarer.
package seq_squarer_pkg;

    // Controller states: waiting for an operand, accumulating partial
    // products one bit per clock, and holding a finished result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sq_state_t;

    // Reference square of the low 'width' bits of 'value'. With is_signed
    // set, the operand is two's complement and its magnitude is squared, so
    // the result is always the non-negative square in 2*width bits.
    function automatic logic [63:0] sq_ref(input logic [31:0] value,
                                           input int width,
                                           input bit is_signed);
        logic [63:0] lim;
        logic [63:0] m;
        lim = 64'd1 << width;
        m   = {32'd0, value} & (lim - 64'd1);
        if (is_signed && (((m >> (width - 1)) & 64'd1) != 64'd0)) begin
            m = lim - m;
        end
        return m * m;
    endfunction

endpackage

// File: rtl/seq_squarer_abs_unit.sv
// Magnitude stage on the operand capture path: conditionally negates a
// two's-complement operand so the datapath only ever squares an unsigned
// value. The most negative operand wraps onto its own bit pattern, which
// read as unsigned is exactly its magnitude.
module sq_abs_unit #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] mag
);

    localparam bit IS_SIGNED = (SIGNED != 0);

    logic neg;

    // Negate only when the operand is signed and its sign bit is set.
    always_comb begin
        neg = IS_SIGNED & a[WIDTH-1];
        mag = neg ? (~a + 1'b1) : a;
    end

endmodule

// File: rtl/seq_squarer.sv
// Multi-cycle squarer: p = a*a using a radix-2 shift-add datapath that
// consumes one operand bit per clock. One 2*WIDTH adder is shared by all
// bit positions, so latency grows with WIDTH while the datapath does not.
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are high. The producer holds in_valid and a stable until that edge;
// in_ready does not wait for in_valid. The block holds out_valid and p
// stable until the consumer's out_ready completes the transfer.
module seq_squarer (
    clk,
    rst,
    in_valid,
    in_ready,
    a,
    out_valid,
    out_ready,
    p
);
    import seq_squarer_pkg::*;

    parameter int WIDTH  = 8;
    parameter int SIGNED = 0;

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    input  logic             clk;
    input  logic             rst;
    input  logic             in_valid;
    output logic             in_ready;
    input  logic [WIDTH-1:0] a;
    output logic             out_valid;
    input  logic             out_ready;
    output logic [PW-1:0]    p;

    sq_state_t         state;
    logic [WIDTH-1:0]  mag;
    logic [WIDTH-1:0]  mag_in;
    logic [PW-1:0]     acc;
    logic [CNT_W-1:0]  cnt;

    logic              take;
    logic [WIDTH-1:0]  mag_sh;
    logic              bit_now;
    logic [PW-1:0]     addend;
    logic [PW-1:0]     acc_sum;

    // Magnitude of the incoming operand, captured only on the handshake.
    sq_abs_unit #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_abs (
        .a   (a),
        .mag (mag_in)
    );

    // Ready when idle, or when the held result leaves this same cycle so a
    // new operand can follow it without a bubble.
    always_comb begin
        in_ready = (state == IDLE) | ((state == DONE) & out_ready);
        take     = in_valid & in_ready;
    end

    // Partial product for the current bit: the magnitude shifted to the bit
    // position, added only when that multiplier bit is set.
    always_comb begin
        mag_sh  = mag >> cnt;
        bit_now = mag_sh[0];
        addend  = {{WIDTH{1'b0}}, mag} << cnt;
        acc_sum = bit_now ? (acc + addend) : acc;
    end

    // Controller and datapath registers; the result is registered on the
    // last accumulation step so p is stable for the whole DONE phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mag       <= '0;
            acc       <= '0;
            cnt       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        mag   <= mag_in;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        p         <= acc_sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            mag   <= mag_in;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_squarer.sv
// Bench for seq_squarer: four configurations (4/unsigned, 4/signed,
// 8/signed, 8/unsigned), each with its own driver and a cycle-level model
// that predicts in_ready, out_valid and p from operand arrival times.
module tb_seq_squarer;
  import seq_squarer_pkg::*;

  localparam int NCFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_edge = 0;
  always @(posedge clk) n_edge <= n_edge + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input int cfg, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %0d, want %0d", cfg, nm, act, req);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W = (g < 2) ? 4 : 8;
    localparam int S = (g == 1 || g == 2) ? 1 : 0;

    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   a = '0;
    logic [2*W-1:0] p;
    bit             rnd_rdy = 1'b0;
    bit             fin = 1'b0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] lit_q[$];

    seq_squarer #(.WIDTH(W), .SIGNED(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
    );

    // Model: a result appears W edges after the accepting edge and stays
    // until consumed; the block accepts when empty or when the held result
    // is consumed this cycle.
    initial begin : cmp
      bit          pend;
      int          ready_at;
      logic        ev;
      logic        er;
      logic [63:0] r;
      pend = 1'b0;
      ready_at = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          pend = 1'b0;
          exp_q.delete();
          lit_q.delete();
          chk(g, "rst_out_valid", 64'(out_valid), 64'd0);
          chk(g, "rst_p", 64'(p), 64'd0);
          chk(g, "rst_in_ready", 64'(in_ready), 64'd1);
        end else begin
          ev = pend && (n_edge >= ready_at);
          er = !pend || (ev && out_ready);
          chk(g, "out_valid", 64'(out_valid), 64'(ev));
          chk(g, "in_ready", 64'(in_ready), 64'(er));
          if (ev) begin
            chk(g, "p", 64'(p), 64'(exp_q[0]));
            if (out_ready) begin
              if (lit_q.size() > 0) chk(g, "p_literal", 64'(p), 64'(lit_q.pop_front()));
              void'(exp_q.pop_front());
              pend = 1'b0;
            end
          end
          if (in_valid && er) begin
            pend = 1'b1;
            ready_at = n_edge + 1 + W;
            r = sq_ref(32'(a), W, S != 0);
            exp_q.push_back(r[2*W-1:0]);
          end
        end
      end
    end

    // Asynchronous reset must clear the outputs before any clock edge.
    initial forever begin
      @(posedge rst);
      #1;
      chk(g, "async_rst_p", 64'(p), 64'd0);
      chk(g, "async_rst_out_valid", 64'(out_valid), 64'd0);
    end

    task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] v, input bit has_lit, input logic [2*W-1:0] lit, input bit hold);
      int t;
      bit hs;
      t = 0;
      hs = 1'b0;
      a = v;
      in_valid = 1'b1;
      if (has_lit) lit_q.push_back(lit);
      while (!hs && t < 200) begin
        @(negedge clk);
        hs = in_ready;
        tick();
        t++;
      end
      if (!hs) chk(g, "send_timeout", 64'd0, 64'd1);
      if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
      int t;
      t = 0;
      rnd_rdy = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && t < 100) begin
        tick();
        t++;
      end
      tick();
      chk(g, "drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : drv
      logic [31:0] r;
      #1 rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      out_ready = 1'b1;
      case (g)
        0: begin
          send(W'(15), 1'b1, (2*W)'(225), 1'b0);
          drain();
        end
        1: begin
          send(W'(8), 1'b1, (2*W)'(64), 1'b0);
          drain();
        end
        2: begin
          send(W'(8'h80), 1'b1, (2*W)'(16384), 1'b0);
          send(W'(8'hFF), 1'b1, (2*W)'(1), 1'b0);
          send(W'(127), 1'b1, (2*W)'(16129), 1'b0);
          send(W'(0), 1'b1, (2*W)'(0), 1'b0);
          drain();
          send(W'(3), 1'b1, (2*W)'(9), 1'b1);
          send(W'(5), 1'b1, (2*W)'(25), 1'b0);
          drain();
        end
        default: begin
          out_ready = 1'b0;
          send(W'(200), 1'b1, (2*W)'(40000), 1'b0);
          repeat (W) tick();
          repeat (5) tick();
          out_ready = 1'b1;
          tick();
          out_ready = 1'b0;
          repeat (2) tick();
          out_ready = 1'b1;
          send(W'(255), 1'b0, '0, 1'b0);
          tick();
          tick();
          #1 rst = 1'b1;
          tick();
          tick();
          rst = 1'b0;
          tick();
          send(W'(2), 1'b1, (2*W)'(4), 1'b0);
          drain();
        end
      endcase
      rnd_rdy = 1'b1;
      if (W == 4) begin
        for (int v = 0; v < 16; v++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(W'(v), 1'b0, '0, 1'b0);
        end
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        r = $urandom;
        send(r[W-1:0], 1'b0, '0, 1'b0);
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin : top
    int t;
    chk(-1, "ref_15_w4u", sq_ref(32'd15, 4, 1'b0), 64'd225);
    chk(-1, "ref_m8_w4s", sq_ref(32'h8, 4, 1'b1), 64'd64);
    chk(-1, "ref_m128_w8s", sq_ref(32'h80, 8, 1'b1), 64'd16384);
    chk(-1, "ref_m1_w8s", sq_ref(32'hFF, 8, 1'b1), 64'd1);
    chk(-1, "ref_200_w8u", sq_ref(32'd200, 8, 1'b0), 64'd40000);
    chk(-1, "ref_min_w32s", sq_ref(32'h80000000, 32, 1'b1), 64'h4000000000000000);
    t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk(-1, "all_cfg_finished", 64'(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
